// File: rtl/temp_sample_filter_if.sv
// Sample-in / filtered-result bundle between the ADC shift stage and the filter.
// The master drives ADC codes and observes the filter results; the slave is the filter.
interface temp_sample_filter_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic [DATA_W-1:0] avg_out;
    logic              avg_valid;
    logic              led;
    logic              alarm_rise;
    logic [DATA_W-1:0] peak_out;
    logic              window_full;

    modport master (
        output sample_in, sample_valid,
        input  avg_out, avg_valid, led, alarm_rise, peak_out, window_full
    );

    modport slave (
        input  sample_in, sample_valid,
        output avg_out, avg_valid, led, alarm_rise, peak_out, window_full
    );
endinterface

// File: rtl/temp_sample_filter.sv
// Moving-average filter over a power-of-two window of ADC temperature codes.
// The filtered value drives a hysteresis LED, a rising-alarm pulse and a peak tracker.
module temp_sample_filter #(
    parameter int                DATA_W   = 8,
    parameter int                AVG_LOG2 = 2,
    parameter logic [DATA_W-1:0] TH_HIGH  = 8'd10,
    parameter logic [DATA_W-1:0] TH_LOW   = 8'd7
) (
    input  logic                 clk,
    input  logic                 rstc,
    temp_sample_filter_if.slave  bus
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic {FILL, RUN} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   win_q [DEPTH];
    logic [DATA_W-1:0]   win_d [DEPTH];
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [AVG_LOG2-1:0] wptr_q, wptr_d;
    logic                pend_q, pend_d;
    logic [DATA_W-1:0]   avg_q, avg_d;
    logic                avg_valid_q, avg_valid_d;
    logic                led_q, led_d;
    logic                alarm_q, alarm_d;
    logic [DATA_W-1:0]   peak_q, peak_d;
    logic [DATA_W-1:0]   new_avg;

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        wptr_d      = wptr_q;
        pend_d      = 1'b0;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        led_d       = led_q;
        alarm_d     = 1'b0;
        peak_d      = peak_q;
        new_avg     = DATA_W'(sum_q >> AVG_LOG2);

        // pend_q marks that sum_q already includes a sample accepted last cycle
        if (pend_q) begin
            avg_d       = new_avg;
            avg_valid_d = 1'b1;
            if (new_avg > TH_HIGH) begin
                led_d = 1'b1;
            end else if (new_avg < TH_LOW) begin
                led_d = 1'b0;
            end
            alarm_d = led_d & ~led_q;
            if (new_avg > peak_q) begin
                peak_d = new_avg;
            end
        end

        if (bus.sample_valid) begin
            sum_d         = sum_q + SUM_W'(bus.sample_in) - SUM_W'(win_q[wptr_q]);
            win_d[wptr_q] = bus.sample_in;
            wptr_d        = wptr_q + 1'b1;
            if (state_q == FILL) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == DEPTH_CNT) begin
                    state_d = RUN;
                    pend_d  = 1'b1;
                end
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstc) begin
            state_q     <= FILL;
            for (int i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
            sum_q       <= '0;
            cnt_q       <= '0;
            wptr_q      <= '0;
            pend_q      <= 1'b0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            led_q       <= 1'b0;
            alarm_q     <= 1'b0;
            peak_q      <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            wptr_q      <= wptr_d;
            pend_q      <= pend_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            led_q       <= led_d;
            alarm_q     <= alarm_d;
            peak_q      <= peak_d;
        end
    end

    assign bus.avg_out     = avg_q;
    assign bus.avg_valid   = avg_valid_q;
    assign bus.led         = led_q;
    assign bus.alarm_rise  = alarm_q;
    assign bus.peak_out    = peak_q;
    assign bus.window_full = (state_q == RUN);
endmodule
